// File: rtl/calc_pkg.sv
// Shared definitions for the parametrised calculator controller:
// op codes, FSM state encoding and error flag bit positions.
package calc_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_DIV  = 3'b101;
    localparam logic [2:0] OP_MOD  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER_A = 3'd1,
        S_ENTER_B = 3'd2,
        S_OP_WAIT = 3'd3,
        S_CALC    = 3'd4,
        S_DIV     = 3'd5,
        S_RESULT  = 3'd6
    } state_t;

    localparam int ERR_OVF   = 0;
    localparam int ERR_DIV0  = 1;
    localparam int ERR_DIGIT = 2;
    localparam int ERR_OP    = 3;

    function automatic logic isDivOp(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/calc_seq_div.sv
// Restoring sequential divider, one quotient bit per cycle. The first bit is
// resolved on the launch edge so results are ready WIDTH cycles after launch.
module calc_seq_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_rem, r_quo, r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_busy, r_done;

    logic [WIDTH-1:0] w_remIn, w_quoIn, w_divIn, w_remNext, w_quoNext;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;

    // The launch edge feeds the step directly from the operands.
    assign w_remIn   = start ? '0 : r_rem;
    assign w_quoIn   = start ? dividend : r_quo;
    assign w_divIn   = start ? divisor : r_div;
    assign w_trial   = {w_remIn, w_quoIn[WIDTH-1]};
    assign w_fits    = w_trial >= {1'b0, w_divIn};
    assign w_remNext = w_fits ? WIDTH'(w_trial - {1'b0, w_divIn}) : w_trial[WIDTH-1:0];
    assign w_quoNext = {w_quoIn[WIDTH-2:0], w_fits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (abort) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem  <= w_remNext;
                r_quo  <= w_quoNext;
                r_div  <= divisor;
                r_cnt  <= CW'(WIDTH - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_remNext;
                r_quo <= w_quoNext;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/calc_ctrl_fsm_p.sv
// Calculator controller: multi-digit decimal operand entry, single-cycle ALU ops
// and a sequential divider, with busy/done handshake and sticky error flags.
module calc_ctrl_fsm_p
    import calc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [3:0]       digit,
    input  logic             digit_valid,
    input  logic             enter,
    input  logic [2:0]       op,
    input  logic             op_valid,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic [3:0]       err
);
    localparam int DCW = $clog2(MAX_DIGITS + 1);
    localparam logic [DCW-1:0] MAX_CNT = DCW'(MAX_DIGITS);

    state_t           r_state, w_nextState;
    logic [WIDTH-1:0] r_a, r_b, r_result;
    logic [2:0]       r_op;
    logic [DCW-1:0]   r_digCnt;
    logic [3:0]       r_err;

    logic [WIDTH-1:0]   w_acc, w_accSat, w_quo, w_rem;
    logic [WIDTH+3:0]   w_accNext;
    logic               w_accOvf, w_divStart, w_divBusy, w_divDone;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;

    // Four spare bits hold acc*10+digit exactly, so overflow is just a nonzero top nibble.
    assign w_acc      = (r_state == S_ENTER_A) ? r_a : r_b;
    assign w_accNext  = (WIDTH+4)'(w_acc) * (WIDTH+4)'(10) + (WIDTH+4)'(digit);
    assign w_accOvf   = |w_accNext[WIDTH+3:WIDTH];
    assign w_accSat   = w_accOvf ? '1 : w_accNext[WIDTH-1:0];
    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_prod     = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
    assign w_divStart = (r_state == S_CALC) && isDivOp(r_op) && (r_b != '0) && !clear;

    calc_seq_div #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .abort     (clear),
        .start     (w_divStart),
        .dividend  (r_a),
        .divisor   (r_b),
        .busy      (w_divBusy),
        .done      (w_divDone),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (clear) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (start)    w_nextState = S_ENTER_A;
                S_ENTER_A: if (enter)    w_nextState = S_ENTER_B;
                S_ENTER_B: if (enter)    w_nextState = S_OP_WAIT;
                S_OP_WAIT: if (op_valid) w_nextState = S_CALC;
                S_CALC:    w_nextState = w_divStart ? S_DIV : S_RESULT;
                S_DIV:     if (w_divDone) w_nextState = S_RESULT;
                S_RESULT:  w_nextState = S_IDLE;
                default:   w_nextState = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != S_IDLE) || w_divBusy;
        done = (r_state == S_RESULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0; r_b <= '0; r_op <= '0; r_digCnt <= '0; r_result <= '0; r_err <= '0;
        end else if (clear) begin
            r_a <= '0; r_b <= '0; r_op <= '0; r_digCnt <= '0; r_result <= '0; r_err <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_a <= '0; r_b <= '0; r_digCnt <= '0; r_result <= '0; r_err <= '0;
                end
                S_ENTER_A, S_ENTER_B: begin
                    if (digit_valid) begin
                        if (digit > 4'd9) begin
                            r_err[ERR_DIGIT] <= 1'b1;
                        end else if (r_digCnt != MAX_CNT) begin
                            if (r_state == S_ENTER_A) r_a <= w_accSat;
                            else                      r_b <= w_accSat;
                            r_digCnt <= r_digCnt + 1'b1;
                            if (w_accOvf) r_err[ERR_OVF] <= 1'b1;
                        end
                    end
                    if (enter) r_digCnt <= '0;
                end
                S_OP_WAIT: if (op_valid) r_op <= op;
                S_CALC: begin
                    case (r_op)
                        OP_ADD: begin
                            r_result <= w_sum[WIDTH-1:0];
                            if (w_sum[WIDTH]) r_err[ERR_OVF] <= 1'b1;
                        end
                        OP_SUB: begin
                            r_result <= r_a - r_b;
                            if (r_a < r_b) r_err[ERR_OVF] <= 1'b1;
                        end
                        OP_AND: r_result <= r_a & r_b;
                        OP_OR:  r_result <= r_a | r_b;
                        OP_MUL: begin
                            r_result <= w_prod[WIDTH-1:0];
                            if (|w_prod[2*WIDTH-1:WIDTH]) r_err[ERR_OVF] <= 1'b1;
                        end
                        OP_DIV, OP_MOD: if (r_b == '0) begin
                            r_result <= '1;
                            r_err[ERR_DIV0] <= 1'b1;
                        end
                        default: begin
                            r_result <= '0;
                            r_err[ERR_OP] <= 1'b1;
                        end
                    endcase
                end
                S_DIV: if (w_divDone) r_result <= (r_op == OP_MOD) ? w_rem : w_quo;
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign err    = r_err;

endmodule

// File: doc/calc_ctrl_fsm_p.md
Name: calc_ctrl_fsm_p

Overview:
Parametrised calculator control FSM, the next generation of the team's 4-bit single-digit calculator controller.
- Operands are entered as multi-digit decimal numbers, WIDTH bits wide.
- Adds a modulo operation and a multi-cycle sequential divider.
- Adds a synchronous clear, busy/done handshake and sticky error flags.
- Sits between the keypad decoder (digits, enter, op) and the display driver (result, done, err).

Parameters:
WIDTH, 8, operand/result width in bits (4..16).
MAX_DIGITS, 3, maximum decimal digits accepted per operand; further digits ignored.

Ports:
clk  in  1  clock.
rst  in  1  reset: asynchronous, active-high.
start  in  1  begin a new calculation; honoured only in IDLE.
clear  in  1  synchronous abort: return to IDLE, zero operands, result and err.
digit  in  4  BCD digit.
digit_valid  in  1  digit qualifier, single-cycle pulse.
enter  in  1  close current operand.
op  in  3  operation code.
op_valid  in  1  op qualifier, honoured only in OP_WAIT.
result  out  WIDTH  registered result, held until next start/clear/rst.
done  out  1  one-cycle pulse when result becomes valid.
busy  out  1  high in every state except IDLE.
err  out  4  sticky flags: [0] overflow, [1] div_by_zero, [2] bad_digit, [3] bad_op.

Behaviour:
- Reset (async) and clear (sync, highest priority after rst, any state):
  - state=IDLE.
  - result=0, done=0, busy=0, err=0, operands A=B=0, digit counter=0.
- States: IDLE, ENTER_A, ENTER_B, OP_WAIT, CALC, DIV, RESULT.
- IDLE -start-> ENTER_A. start also clears A, B, err and the digit counter.
- ENTER_A / ENTER_B digit handling, on digit_valid:
  - digit>9: ignored, err[2] set.
  - digit counter = MAX_DIGITS: ignored.
  - otherwise acc = acc*10 + digit, computed at WIDTH+4 bits.
  - If the sum exceeds 2^WIDTH-1: acc saturates to all-ones and err[0] is set.
- Transitions on enter:
  - ENTER_A -enter-> ENTER_B; ENTER_B -enter-> OP_WAIT.
  - The digit counter resets on each transition.
  - Zero digits entered gives operand 0.
- digit_valid and enter in the same cycle: the digit is accumulated first, then the operand closes.
- OP_WAIT -op_valid-> CALC; op is latched on the same edge.
- CALC (exactly one cycle), results written to the result register:
  - 000 A+B: low WIDTH bits; carry sets err[0].
  - 001 A-B: low WIDTH bits (two's-complement wrap); borrow sets err[0].
  - 010 A&B.
  - 011 A|B.
  - 100 A*B: low WIDTH bits; any nonzero upper bit sets err[0].
  - 101 A/B, 110 A%B: if B=0, result = all-ones, err[1] set, go directly to RESULT; else start divider, go to DIV.
  - 111: result=0, err[3] set.
  - All non-divider paths: CALC -> RESULT.
- DIV:
  - Wait for divider done: exactly WIDTH cycles after the launch edge, no early termination.
  - Latch quotient (101) or remainder (110) into result, then go to RESULT.
- RESULT: done=1 for this single cycle, then -> IDLE. result and err are held in IDLE.
- Latency from the op_valid sampling edge to done high:
  - non-divide ops and divide-by-zero: 2 edges.
  - divide/mod: WIDTH+2 edges.
- start outside IDLE: ignored. op_valid outside OP_WAIT: ignored. digit_valid outside ENTER_*: ignored.
- clear during DIV: the divider is aborted (its own start/state forced idle) and no done pulse is issued.

Decomposition:
- Package calc_pkg:
  - op-code localparams (OP_ADD..OP_RSVD).
  - state encoding enum (3 bits).
  - err bit index constants (ERR_OVF, ERR_DIV0, ERR_DIGIT, ERR_OP).
- Sub-module calc_seq_div: restoring divider.
  - Parameter WIDTH; ports clk, rst, abort, start, dividend, divisor, busy, done, quotient, remainder.
  - One quotient bit per cycle.

Test Plan:
- WIDTH=8: start; digits 1,2 enter; digit 3 enter; op=000 -> result=15, err=0, done exactly 2 edges after op_valid.
- Digits 2,5,5,9 for A (MAX_DIGITS=3) -> A=255. Digits 3,0,0 for B -> B=255, err[0]=1. Then op=011 -> result=255.
- A=200, B=100, op=000 -> result=44, err[0]=1. Op=001 with A=5, B=7 -> result=254, err[0]=1.
- A=100, B=7, op=101 -> result=14 with done WIDTH+2=10 edges after op_valid. Repeat with op=110 -> result=2, busy high throughout.
- A=9, B=0, op=101 -> result=255, err[1]=1, done after 2 edges. Digit 0xC during entry -> err[2]=1, digit ignored.
- Assert clear, then separately rst, mid-DIV -> next edge (clear) or immediately (rst): state IDLE, busy=0, result=0, err=0, no done pulse. A new calculation then completes correctly.
